// File: rtl/neokeon_host_seq.sv
// Host-side sequencer for the Neokeon coprocessor write interface.
// Optional watchdog in WAIT: define NEOKEON_HOST_TIMEOUT_EN.
module neokeon_host_seq #(
    parameter int KEY_REQUIRED   = 1,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic         inClk,
    input  logic         inRst,
    input  logic [31:0]  inWord,
    input  logic         inWordIsKey,
    input  logic         inWordValid,
    output logic         outWordReady,
    output logic [31:0]  outResWord,
    output logic         outResValid,
    input  logic         inResReady,
    output logic         outErr,
    output logic [127:0] outExtKey,
    output logic         outExtKeyWr,
    output logic [127:0] outExtData,
    output logic         outExtDataWr,
    input  logic         inCoreBusy,
    input  logic [127:0] inCoreDataOut
);

`ifdef NEOKEON_HOST_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_KEY_WR,
        ST_DATA_WR,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t state;
    state_t nextState;

    logic [127:0]     blockReg;
    logic [127:0]     resReg;
    logic [1:0]       wordCnt;
    logic [1:0]       resIdx;
    logic             isKeyReg;
    logic             keyLoaded;
    logic [CNT_W-1:0] waitCnt;

    logic         wordAccept;
    logic         lastWord;
    logic         dropBlock;
    logic         resAccept;
    logic         timeoutHit;
    logic [127:0] fullBlock;

    assign wordAccept = inWordValid & outWordReady;
    assign lastWord   = wordAccept & (wordCnt == 2'd3);
    assign fullBlock  = {blockReg[95:0], inWord};
    assign resAccept  = outResValid & inResReady;

    // A data block with no key loaded since reset is dropped when keys are mandatory
    assign dropBlock = lastWord & ~isKeyReg & ~keyLoaded
                     & (KEY_REQUIRED != 0);

    // Watchdog fires when the core is still busy on the last allowed WAIT cycle
    assign timeoutHit = TIMEOUT_EN & (state == ST_WAIT) & inCoreBusy
                      & (waitCnt == WAIT_LIMIT);

    // Result word selection, most significant word first
    always_comb begin
        outResWord = resReg[{~resIdx, 5'b0} +: 32];
    end

    // State register
    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            state <= ST_COLLECT;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and state-decoded handshakes/strobes
    always_comb begin
        nextState    = state;
        outWordReady = 1'b0;
        outResValid  = 1'b0;
        outExtKeyWr  = 1'b0;
        outExtDataWr = 1'b0;
        unique case (state)
            ST_COLLECT: begin
                outWordReady = ~inCoreBusy & ~inRst;
                if (lastWord && !dropBlock) begin
                    nextState = isKeyReg ? ST_KEY_WR : ST_DATA_WR;
                end
            end
            ST_KEY_WR: begin
                outExtKeyWr = 1'b1;
                nextState   = ST_COLLECT;
            end
            ST_DATA_WR: begin
                outExtDataWr = 1'b1;
                nextState    = ST_WAIT;
            end
            ST_WAIT: begin
                if (!inCoreBusy) begin
                    nextState = ST_OUT;
                end else if (timeoutHit) begin
                    nextState = ST_COLLECT;
                end
            end
            ST_OUT: begin
                outResValid = 1'b1;
                if (resAccept && resIdx == 2'd3) begin
                    nextState = ST_COLLECT;
                end
            end
            default: nextState = ST_COLLECT;
        endcase
    end

    // Block assembly, core buses, result capture, error pulse and watchdog
    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            blockReg   <= '0;
            resReg     <= '0;
            wordCnt    <= '0;
            resIdx     <= '0;
            isKeyReg   <= 1'b0;
            keyLoaded  <= 1'b0;
            waitCnt    <= '0;
            outErr     <= 1'b0;
            outExtKey  <= '0;
            outExtData <= '0;
        end else begin
            outErr <= dropBlock | timeoutHit;
            if (wordAccept) begin
                blockReg <= fullBlock;
                wordCnt  <= wordCnt + 2'd1;
                if (wordCnt == 2'd0) begin
                    isKeyReg <= inWordIsKey;
                end
            end
            if (lastWord && !dropBlock) begin
                if (isKeyReg) begin
                    outExtKey <= fullBlock;
                end else begin
                    outExtData <= fullBlock;
                end
            end
            if (state == ST_KEY_WR) begin
                keyLoaded <= 1'b1;
            end
            if (state == ST_WAIT && !inCoreBusy) begin
                resReg <= inCoreDataOut;
                resIdx <= 2'd0;
            end else if (resAccept) begin
                resIdx <= resIdx + 2'd1;
            end
            if (state == ST_WAIT) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end else begin
                waitCnt <= '0;
            end
        end
    end

endmodule
